// File: rtl/seq_mul_div.sv
// seq_mul_div: shared multi-cycle arithmetic unit. It does a signed radix-2 Booth
// multiply (mode 0) or an unsigned restoring divide (mode 1) on N-bit operands.
// Latency: start is sampled at edge E0 and done pulses for the cycle after edge EN.
// Backpressure: none. start is accepted only in IDLE or DONE and ignored while busy.
//
// The optional macro SEQ_ARITH_DIV_EN turns on the divider datapath. When it is not
// defined, mode is ignored, every operation is a multiply, and div_by_zero stays 0.
//
// Ports:
//   clk, rst              rising-edge clock; asynchronous active-high reset
//   start, mode, a, b     operation request; all are sampled together with start
//   busy                  high while the unit is iterating (state RUN)
//   done                  single-cycle pulse (state DONE); results are valid from here
//   result_hi/result_lo   product upper/lower half, or remainder/quotient
//   div_by_zero           a divide with b == 0 has completed; the next multiply clears it
module seq_mul_div #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result_hi,
   output logic [N-1:0] result_lo,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_nxt;

   // Working registers. acc is one bit wider than the operands so that the Booth
   // sums cannot overflow (a = -2^(N-1) is exact) and so that the sign of the
   // divide trial subtraction is visible.
   logic [N:0]     acc;
   logic [N:0]     m_reg;
   logic [N-1:0]   q;
   logic           q_1;
   logic [CW-1:0]  cnt;

   logic           accept;
   logic           last;
   logic           is_div;

   logic [N:0]     booth_sum;
   logic [N:0]     mul_acc;
   logic [N-1:0]   mul_q;

   logic [N:0]     acc_nxt;
   logic [N-1:0]   q_nxt;
   logic           q1_nxt;
   logic           dbz_nxt;

   assign accept = start && ((state == IDLE) || (state == DONE));
   // This is the edge on which the counter goes from 1 to 0, which is the final iteration.
   assign last   = (state == RUN) && (cnt == CW'(1));

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- Booth step
   // Use {Q[0], q_1} to choose add, subtract or no change. Then shift the whole
   // {A, Q, q_1} chain right by one bit, keeping the sign of A.
   always_comb begin
      booth_sum = acc;
      case ({q[0], q_1})
         2'b01:   booth_sum = acc + m_reg;
         2'b10:   booth_sum = acc - m_reg;
         default: booth_sum = acc;
      endcase
      mul_acc = {booth_sum[N], booth_sum[N:1]};
      mul_q   = {booth_sum[0], q[N-1:1]};
   end

`ifdef SEQ_ARITH_DIV_EN
   logic           mode_r;
   logic [N:0]     div_sh;
   logic [N:0]     div_diff;
   logic [N:0]     div_acc;
   logic [N-1:0]   div_q;

   // Restoring divide step. Shift {A, Q} left and try A - M. If the result is
   // negative, keep the shifted A; this is the same as subtracting and adding M back.
   // When M == 0 the subtraction never goes negative. That alone produces
   // quotient = all ones and remainder = a, so no special case is needed.
   always_comb begin
      div_sh   = {acc[N-1:0], q[N-1]};
      div_diff = div_sh - m_reg;
      if (div_diff[N]) begin
         div_acc = div_sh;
         div_q   = {q[N-2:0], 1'b0};
      end else begin
         div_acc = div_diff;
         div_q   = {q[N-2:0], 1'b1};
      end
   end

   assign is_div = mode_r;
`else
   // mode has no effect in a multiply-only build.
   logic unused_mode;
   assign unused_mode = mode;
   assign is_div      = 1'b0;
`endif

   always_comb begin
      acc_nxt = mul_acc;
      q_nxt   = mul_q;
      q1_nxt  = q[0];
      dbz_nxt = 1'b0;
`ifdef SEQ_ARITH_DIV_EN
      if (is_div) begin
         acc_nxt = div_acc;
         q_nxt   = div_q;
         q1_nxt  = q_1;
         dbz_nxt = (m_reg == '0);
      end
`endif
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         m_reg       <= '0;
         q           <= '0;
         q_1         <= 1'b0;
         cnt         <= '0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_ARITH_DIV_EN
         mode_r      <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            acc <= '0;
            q_1 <= 1'b0;
            cnt <= CW'(N);
`ifdef SEQ_ARITH_DIV_EN
            mode_r <= mode;
            if (mode) begin
               m_reg <= {1'b0, b};
               q     <= a;
            end else begin
               m_reg <= {a[N-1], a};
               q     <= b;
            end
`else
            m_reg <= {a[N-1], a};
            q     <= b;
`endif
         end else if (state == RUN) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            q_1 <= q1_nxt;
            cnt <= cnt - CW'(1);
            // The results are written only here, so they hold through IDLE and the next RUN.
            if (last) begin
               result_hi   <= acc_nxt[N-1:0];
               result_lo   <= q_nxt;
               div_by_zero <= dbz_nxt;
            end
         end
      end
   end

endmodule
